// File: rtl/psum_gbf_drain_pkg.sv
// psum_gbf_drain_pkg: shared psum gbf geometry defaults and drain FSM states,
// so the gbf wrapper, the drain top and its line serializer agree.
package psum_gbf_drain_pkg;

    localparam int PSUM_GBF_DATA_BITWIDTH = 512;
    localparam int PSUM_GBF_ADDR_BITWIDTH = 5;
    localparam int PSUM_GBF_DEPTH         = 32;
    localparam int STREAM_BITWIDTH        = 128;
    localparam int BEATS = PSUM_GBF_DATA_BITWIDTH / STREAM_BITWIDTH;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SEND    = 3'd3,
        ST_FIN     = 3'd4
    } drain_state_e;

    // Width of a beat index; never zero even for a single-beat line.
    function automatic int beat_idx_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/psum_gbf_drain_line_serializer.sv
// psum_gbf_drain_line_serializer: holds one psum line and emits it as
// D/S beats (LSB slice first) on a valid/ready stream.
// Ports: load/line_in/last_in (new line), m_valid/m_ready/m_data/m_last
// (beat stream), line_done (handshake of the final beat of the line).
module psum_gbf_drain_line_serializer
    import psum_gbf_drain_pkg::*;
#(
    parameter int D = PSUM_GBF_DATA_BITWIDTH,
    parameter int S = STREAM_BITWIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [D-1:0] line_in,
    input  logic         last_in,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [S-1:0] m_data,
    output logic         m_last,
    output logic         line_done
);

    localparam int NB = D / S;
    localparam int BW = beat_idx_w(NB);
    localparam logic [BW-1:0] LAST_BEAT = BW'(NB - 1);
    localparam logic [BW-1:0] BEAT_ONE  = BW'(1);

    logic [D-1:0]  line_q, line_d;
    logic [BW-1:0] beat_q, beat_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;

    logic [S-1:0]  beat_data [NB];
    logic          fire;
    logic          on_last;

    for (genvar g = 0; g < NB; g++) begin : g_beat
        assign beat_data[g] = line_q[g*S +: S];
    end

    assign fire    = valid_q && m_ready;
    assign on_last = (beat_q == LAST_BEAT);

    always_comb begin
        line_d  = line_q;
        beat_d  = beat_q;
        valid_d = valid_q;
        last_d  = last_q;
        if (load) begin
            line_d  = line_in;
            last_d  = last_in;
            valid_d = 1'b1;
            beat_d  = '0;
        end else if (fire) begin
            if (on_last) begin
                valid_d = 1'b0;
                beat_d  = '0;
            end else begin
                beat_d = beat_q + BEAT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q  <= '0;
            beat_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            line_q  <= line_d;
            beat_q  <= beat_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign m_valid   = valid_q;
    assign m_data    = beat_data[beat_q];
    assign m_last    = valid_q && last_q && on_last;
    assign line_done = fire && on_last;

endmodule

// File: rtl/psum_gbf_drain.sv
// psum_gbf_drain: drains a retired psum gbf bank line by line, zeroing each
// line after reading it and streaming it out as narrow beats.
// Ports: drain_start/bank/len (command), r_en/r_addr/r_data1b/r_data2b
// (gbf read), init_en/init_addr (zero-init write), m_* (beat stream),
// busy/done (status).
module psum_gbf_drain
    import psum_gbf_drain_pkg::*;
#(
    parameter int PSUM_GBF_DATA_BITWIDTH_P = PSUM_GBF_DATA_BITWIDTH,
    parameter int PSUM_GBF_ADDR_BITWIDTH_P = PSUM_GBF_ADDR_BITWIDTH,
    parameter int PSUM_GBF_DEPTH_P         = PSUM_GBF_DEPTH,
    parameter int STREAM_BITWIDTH_P        = STREAM_BITWIDTH
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                drain_start,
    input  logic                                drain_bank,
    input  logic [PSUM_GBF_ADDR_BITWIDTH_P:0]   drain_len,
    output logic                                r_en,
    output logic [PSUM_GBF_ADDR_BITWIDTH_P-1:0] r_addr,
    input  logic [PSUM_GBF_DATA_BITWIDTH_P-1:0] r_data1b,
    input  logic [PSUM_GBF_DATA_BITWIDTH_P-1:0] r_data2b,
    output logic                                init_en,
    output logic [PSUM_GBF_ADDR_BITWIDTH_P-1:0] init_addr,
    output logic                                m_valid,
    input  logic                                m_ready,
    output logic [STREAM_BITWIDTH_P-1:0]        m_data,
    output logic                                m_last,
    output logic                                busy,
    output logic                                done
);

    localparam int A   = PSUM_GBF_ADDR_BITWIDTH_P;
    localparam int D   = PSUM_GBF_DATA_BITWIDTH_P;
    localparam int S   = STREAM_BITWIDTH_P;
    localparam int AW1 = A + 1;
    localparam logic [A:0] DEPTH_L = AW1'(PSUM_GBF_DEPTH_P);
    localparam logic [A:0] CNT_ONE = AW1'(1);

    drain_state_e state_q, state_d;
    logic         bank_q, bank_d;
    logic [A:0]   len_q, len_d;
    logic [A:0]   line_cnt_q, line_cnt_d;
    logic         r_en_q, r_en_d;
    logic [A-1:0] r_addr_q, r_addr_d;
    logic         init_en_q, init_en_d;
    logic [A-1:0] init_addr_q, init_addr_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic [A:0]   len_clamp;
    logic [A:0]   cnt_inc;
    logic [D-1:0] line_sel;
    logic         ser_load;
    logic         ser_last;
    logic         ser_line_done;

    // Oversized requests drain the whole bank and never wrap the address.
    assign len_clamp = (drain_len > DEPTH_L) ? DEPTH_L : drain_len;
    assign cnt_inc   = line_cnt_q + CNT_ONE;
    assign line_sel  = bank_q ? r_data2b : r_data1b;

    always_comb begin
        state_d     = state_q;
        bank_d      = bank_q;
        len_d       = len_q;
        line_cnt_d  = line_cnt_q;
        r_en_d      = 1'b0;
        r_addr_d    = '0;
        init_en_d   = 1'b0;
        init_addr_d = '0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        ser_load    = 1'b0;
        ser_last    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (drain_start) begin
                    bank_d     = drain_bank;
                    len_d      = len_clamp;
                    line_cnt_d = '0;
                    if (len_clamp == '0) begin
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_FETCH;
                        r_en_d  = 1'b1;
                        busy_d  = 1'b1;
                    end
                end
            end
            ST_FETCH: begin
                // Zero the line in the same cycle its read data is captured.
                state_d     = ST_CAPTURE;
                init_en_d   = 1'b1;
                init_addr_d = line_cnt_q[A-1:0];
            end
            ST_CAPTURE: begin
                state_d  = ST_SEND;
                ser_load = 1'b1;
                ser_last = (cnt_inc == len_q);
            end
            ST_SEND: begin
                if (ser_line_done) begin
                    line_cnt_d = cnt_inc;
                    if (cnt_inc < len_q) begin
                        state_d  = ST_FETCH;
                        r_en_d   = 1'b1;
                        r_addr_d = cnt_inc[A-1:0];
                    end else begin
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bank_q      <= 1'b0;
            len_q       <= '0;
            line_cnt_q  <= '0;
            r_en_q      <= 1'b0;
            r_addr_q    <= '0;
            init_en_q   <= 1'b0;
            init_addr_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bank_q      <= bank_d;
            len_q       <= len_d;
            line_cnt_q  <= line_cnt_d;
            r_en_q      <= r_en_d;
            r_addr_q    <= r_addr_d;
            init_en_q   <= init_en_d;
            init_addr_q <= init_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    psum_gbf_drain_line_serializer #(
        .D (D),
        .S (S)
    ) u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ser_load),
        .line_in   (line_sel),
        .last_in   (ser_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .line_done (ser_line_done)
    );

    assign r_en      = r_en_q;
    assign r_addr    = r_addr_q;
    assign init_en   = init_en_q;
    assign init_addr = init_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_psum_gbf_drain.sv
// tb_psum_gbf_drain: table-driven and randomized bench for psum_gbf_drain,
// with a two-bank gbf model and a beat-queue reference model.
module tb_psum_gbf_drain;

    localparam int D     = 512;
    localparam int A     = 5;
    localparam int DEPTH = 32;
    localparam int S     = 128;
    localparam int NB    = D / S;
    localparam int AW1   = A + 1;

    typedef struct {
        logic  bank;
        int    len;
        int    mode;
        int    fill;
        int    repulse;
        int    exp_lines;
        int    exp_beats;
        int    exp_last;
        string nm;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         drain_start;
    logic         drain_bank;
    logic [A:0]   drain_len;
    logic         r_en;
    logic [A-1:0] r_addr;
    logic [D-1:0] r_data1b;
    logic [D-1:0] r_data2b;
    logic         init_en;
    logic [A-1:0] init_addr;
    logic         m_valid;
    logic         m_ready;
    logic [S-1:0] m_data;
    logic         m_last;
    logic         busy;
    logic         done;

    int errors = 0;
    int checks = 0;

    logic [D-1:0] mem [2][DEPTH];
    logic         cur_bank;
    logic         fill_go;
    int           fill_mode;
    int           ready_mode;

    logic [S-1:0] od[$];
    bit           ol[$];
    int           rq[$];
    int           iq[$];
    int           stall_viol = 0;
    int           overlap_viol = 0;
    int           done_cnt = 0;
    bit           pv = 0;
    bit           pstall = 0;
    logic [S-1:0] pd = '0;
    logic         pl = 1'b0;

    always #5 clk = ~clk;

    psum_gbf_drain dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .drain_start (drain_start),
        .drain_bank  (drain_bank),
        .drain_len   (drain_len),
        .r_en        (r_en),
        .r_addr      (r_addr),
        .r_data1b    (r_data1b),
        .r_data2b    (r_data2b),
        .init_en     (init_en),
        .init_addr   (init_addr),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .busy        (busy),
        .done        (done)
    );

    // gbf model: registered reads on both banks, zero-init on the drained bank
    always @(posedge clk) begin
        if (fill_go) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (fill_mode == 0) begin
                        for (int k = 0; k < NB; k++)
                            mem[b][i][k*S +: S] = S'(b * 256 + i + 1);
                    end else begin
                        for (int k = 0; k < D / 32; k++)
                            mem[b][i][k*32 +: 32] = $urandom | 32'h1;
                    end
                end
            end
        end
        if (r_en) begin
            r_data1b <= mem[0][r_addr];
            r_data2b <= mem[1][r_addr];
        end
        if (init_en) mem[cur_bank][init_addr] = '0;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            pv = 0;
            pstall = 0;
        end else begin
            if (pstall && (!m_valid || m_data != pd || m_last != pl))
                stall_viol++;
            if (m_valid && (r_en || init_en)) overlap_viol++;
            if (m_valid && m_ready) begin
                od.push_back(m_data);
                ol.push_back(m_last);
            end
            if (r_en) rq.push_back(int'(r_addr));
            if (init_en) iq.push_back(int'(init_addr));
            if (done) done_cnt++;
            pv = m_valid;
            pstall = m_valid && !m_ready;
            pd = m_data;
            pl = m_last;
        end
    end

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: m_ready = 1'b1;
                1: m_ready = ~m_ready;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    function automatic void chk(input string nm, input longint act, input longint want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, want);
        end
    endfunction

    function automatic void chk_d(input string nm, input logic [D-1:0] act, input logic [D-1:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, want);
        end
    endfunction

    task automatic do_fill(input int m);
        @(posedge clk);
        #1;
        fill_mode = m;
        fill_go = 1'b1;
        @(posedge clk);
        #1;
        fill_go = 1'b0;
    endtask

    task automatic run_drain(input vec_t v);
        logic [D-1:0] snap [2][DEPTH];
        logic [D-1:0] want;
        logic [S-1:0] ed[$];
        bit           el[$];
        int n, cyc, b0, r0, i0, sv0, ov0, d0, bad, nobs;
        bit seen;
        if (v.fill >= 0) do_fill(v.fill);
        snap = mem;
        n = (v.len > DEPTH) ? DEPTH : v.len;
        for (int i = 0; i < n; i++)
            for (int k = 0; k < NB; k++) begin
                ed.push_back(snap[v.bank][i][k*S +: S]);
                el.push_back(i == n - 1 && k == NB - 1);
            end
        b0 = od.size();
        r0 = rq.size();
        i0 = iq.size();
        sv0 = stall_viol;
        ov0 = overlap_viol;
        d0 = done_cnt;
        ready_mode = v.mode;
        cur_bank = v.bank;
        @(posedge clk);
        #1;
        drain_start = 1'b1;
        drain_bank = v.bank;
        drain_len = AW1'(v.len);
        @(posedge clk);
        #1;
        drain_start = 1'b0;
        cyc = 1;
        seen = 0;
        chk({v.nm, "_busy_start"}, busy, (n > 0) ? 1 : 0);
        while (!seen && cyc < 4000) begin
            if (done) begin
                seen = 1;
            end else begin
                if (cyc == v.repulse) begin
                    drain_start = 1'b1;
                    drain_bank = ~v.bank;
                    drain_len = AW1'(1);
                end
                @(posedge clk);
                #1;
                drain_start = 1'b0;
                cyc++;
            end
        end
        chk({v.nm, "_done_seen"}, seen, 1);
        if (v.mode == 0) chk({v.nm, "_latency"}, cyc, n * (2 + NB) + 1);
        chk({v.nm, "_busy_at_done"}, busy, 0);
        @(posedge clk);
        #1;
        chk({v.nm, "_done_pulses"}, done_cnt - d0, 1);
        nobs = od.size() - b0;
        chk({v.nm, "_beats"}, nobs, v.exp_beats);
        for (int k = 0; k < ed.size() && k < nobs; k++) begin
            chk_d({v.nm, "_beat_data"}, D'(od[b0 + k]), D'(ed[k]));
            chk({v.nm, "_beat_last"}, ol[b0 + k], el[k]);
        end
        chk({v.nm, "_reads"}, rq.size() - r0, v.exp_lines);
        chk({v.nm, "_inits"}, iq.size() - i0, v.exp_lines);
        bad = 0;
        for (int k = 0; k < rq.size() - r0; k++) if (rq[r0 + k] != k) bad++;
        for (int k = 0; k < iq.size() - i0; k++) if (iq[i0 + k] != k) bad++;
        chk({v.nm, "_addr_order"}, bad, 0);
        if (v.exp_lines > 0 && rq.size() > r0)
            chk({v.nm, "_last_addr"}, rq[rq.size() - 1], v.exp_last);
        chk({v.nm, "_stall_hold"}, stall_viol - sv0, 0);
        chk({v.nm, "_overlap"}, overlap_viol - ov0, 0);
        bad = 0;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < DEPTH; i++) begin
                want = (b == int'(v.bank) && i < n) ? '0 : snap[b][i];
                if (mem[b][i] !== want) bad++;
            end
        chk({v.nm, "_mem_zeroing"}, bad, 0);
    endtask

    vec_t         vecs[6];
    vec_t         rv;
    logic [D-1:0] line2;
    int           rlen, rn;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drain_start = 1'b0;
        drain_bank = 1'b0;
        drain_len = '0;
        fill_go = 1'b0;
        fill_mode = 0;
        cur_bank = 1'b0;
        ready_mode = 0;
        r_data1b = '0;
        r_data2b = '0;

        vecs[0] = '{1'b0,  4, 0, 0, -1,  4,  16,  3, "len4_b0"};
        vecs[1] = '{1'b1,  2, 1, 0, -1,  2,   8,  1, "len2_b1_stall"};
        vecs[2] = '{1'b0,  0, 0, 0, -1,  0,   0,  0, "len0"};
        vecs[3] = '{1'b0, 32, 0, 1, -1, 32, 128, 31, "len32"};
        vecs[4] = '{1'b0, 40, 0, 1, -1, 32, 128, 31, "len40_clamp"};
        vecs[5] = '{1'b1,  3, 0, 0,  5,  3,  12,  2, "restart_ignored"};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_r_en", r_en, 0);
        chk("rst_init_en", init_en, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk_d("rst_m_data", D'(m_data), '0);
        rst_n = 1'b1;

        foreach (vecs[t]) run_drain(vecs[t]);

        // Reset during SEND of line 1 of a 3-line drain.
        do_fill(0);
        line2 = mem[0][2];
        cur_bank = 1'b0;
        ready_mode = 0;
        @(posedge clk);
        #1;
        drain_start = 1'b1;
        drain_bank = 1'b0;
        drain_len = AW1'(3);
        @(posedge clk);
        #1;
        drain_start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("mid_in_send", m_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", |{r_en, r_addr, init_en, init_addr, m_valid,
                              m_data, m_last, busy, done}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk_d("mid_rst_line2_kept", mem[0][2], line2);
        chk_d("mid_rst_line0_zeroed", mem[0][0], '0);
        rv = '{1'b0, 3, 0, -1, -1, 3, 12, 2, "post_rst"};
        run_drain(rv);

        for (int r = 0; r < 6; r++) begin
            rlen = $urandom_range(1, 40);
            rn = (rlen > DEPTH) ? DEPTH : rlen;
            rv = '{1'($urandom_range(0, 1)), rlen, 2, 1, -1,
                   rn, rn * NB, rn - 1, "rand"};
            run_drain(rv);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
